// File: rtl/arb_mux2_if.sv
// Handshake bundle for arb_mux2: two upstream sources and one merged
// downstream port. The *_last signals exist only when
// ARB_MUX2_PKT_LOCK_EN is defined.
interface arb_mux2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;
`ifdef ARB_MUX2_PKT_LOCK_EN
    logic             in1_last;
    logic             in2_last;
    logic             out_last;

    // Arbiter side
    modport slave (
        input  in1, in1_valid, in1_last, in2, in2_valid, in2_last, out_ready,
        output in1_ready, in2_ready, out, out_valid, out_sel, out_last
    );
    // Source/sink side
    modport master (
        output in1, in1_valid, in1_last, in2, in2_valid, in2_last, out_ready,
        input  in1_ready, in2_ready, out, out_valid, out_sel, out_last
    );
`else
    // Arbiter side
    modport slave (
        input  in1, in1_valid, in2, in2_valid, out_ready,
        output in1_ready, in2_ready, out, out_valid, out_sel
    );
    // Source/sink side
    modport master (
        output in1, in1_valid, in2, in2_valid, out_ready,
        input  in1_ready, in2_ready, out, out_valid, out_sel
    );
`endif
endinterface

// File: rtl/arb_mux2.sv
// arb_mux2: two-input round-robin stream arbiter with a one-entry
// registered output stage. Optional packet lock under the macro
// ARB_MUX2_PKT_LOCK_EN keeps the grant on one source until its last beat.
module arb_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    arb_mux2_if.slave  bus
);
    logic [1:0][WIDTH-1:0] din;
    logic [WIDTH-1:0]      out_q;
    logic                  out_valid_q;
    logic                  out_sel_q;
    logic                  last_grant;
    logic                  load;
    logic                  have;
    logic                  c;
    logic                  take;

    assign din  = {bus.in2, bus.in1};
    assign load = !out_valid_q || bus.out_ready;

`ifdef ARB_MUX2_PKT_LOCK_EN
    logic locked;
    logic lock_src;
    logic out_last_q;
    logic clast;

    assign clast        = c ? bus.in2_last : bus.in1_last;
    assign bus.out_last = out_last_q;
`endif

    // Pick a source: round-robin on contention, forced to the lock owner mid-packet
    always_comb begin
        c    = 1'b0;
        have = bus.in1_valid || bus.in2_valid;
        if (bus.in1_valid && bus.in2_valid)
            c = !last_grant;
        else if (bus.in2_valid)
            c = 1'b1;
`ifdef ARB_MUX2_PKT_LOCK_EN
        if (locked) begin
            c    = lock_src;
            have = lock_src ? bus.in2_valid : bus.in1_valid;
        end
`endif
    end

    // A beat moves only when the output slot frees up and reset is low
    assign take          = !rst && load && have;
    assign bus.in1_ready = take && !c;
    assign bus.in2_ready = take && c;

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 1'b0;
            last_grant  <= 1'b1;
`ifdef ARB_MUX2_PKT_LOCK_EN
            locked      <= 1'b0;
            lock_src    <= 1'b0;
            out_last_q  <= 1'b0;
`endif
        end else if (load) begin
            if (have) begin
                out_q       <= din[c];
                out_sel_q   <= c;
                out_valid_q <= 1'b1;
`ifdef ARB_MUX2_PKT_LOCK_EN
                out_last_q  <= clast;
                // Pointer only advances at packet boundaries
                if (clast) begin
                    locked     <= 1'b0;
                    last_grant <= c;
                end else begin
                    locked     <= 1'b1;
                    lock_src   <= c;
                end
`else
                last_grant  <= c;
`endif
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arb_mux2.sv
// Directed bench for arb_mux2. Inputs change and readies are sampled on
// the falling edge; registered outputs are sampled one falling edge after
// the rising edge that loads them.
module tb_arb_mux2;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    arb_mux2_if #(.WIDTH(8)) bus ();

    arb_mux2 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rdy(input string tag, input logic r1, input logic r2);
        #1;
        chk({tag, "_r1"}, bus.in1_ready, r1);
        chk({tag, "_r2"}, bus.in2_ready, r2);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        chk({tag, "_v"}, bus.out_valid, v);
        chk({tag, "_d"}, bus.out, d);
        chk({tag, "_s"}, bus.out_sel, s);
    endtask

    initial begin
        // Reset with both sources valid
        rst = 1'b1;
        bus.in1 = 8'h11; bus.in1_valid = 1'b1;
        bus.in2 = 8'h22; bus.in2_valid = 1'b1;
        bus.out_ready = 1'b1;
`ifdef ARB_MUX2_PKT_LOCK_EN
        bus.in1_last = 1'b1;
        bus.in2_last = 1'b1;
`endif
        @(negedge clk);
        chk_rdy("rst0", 1'b0, 1'b0);
        tick();
        chk_rdy("rst1", 1'b0, 1'b0);
        tick();
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        chk_rdy("rst2", 1'b0, 1'b0);
`ifdef ARB_MUX2_PKT_LOCK_EN
        chk("rst_last", bus.out_last, 1'b0);
`endif

        // Contention: in1 first after reset, then alternate
        rst = 1'b0;
        chk_rdy("cont0", 1'b1, 1'b0);
        tick(); chk_out("cont0", 1'b1, 8'h11, 1'b0);
        chk_rdy("cont1", 1'b0, 1'b1);
        tick(); chk_out("cont1", 1'b1, 8'h22, 1'b1);
        chk_rdy("cont2", 1'b1, 1'b0);
        tick(); chk_out("cont2", 1'b1, 8'h11, 1'b0);
        chk_rdy("cont3", 1'b0, 1'b1);
        tick(); chk_out("cont3", 1'b1, 8'h22, 1'b1);

        // Single source, back to back, no bubbles
        bus.in1_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in2 = 8'(i);
            chk_rdy("single", 1'b0, 1'b1);
            tick();
            chk_out("single", 1'b1, 8'(i), 1'b1);
        end

        // Backpressure: hold 0xAA from in1
        bus.in1 = 8'hAA; bus.in1_valid = 1'b1; bus.in2_valid = 1'b0;
        chk_rdy("bp_load", 1'b1, 1'b0);
        tick(); chk_out("bp_load", 1'b1, 8'hAA, 1'b0);
        bus.out_ready = 1'b0;
        bus.in1 = 8'h33; bus.in2 = 8'h44; bus.in2_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp_stall", 1'b0, 1'b0);
            tick();
            chk_out("bp_stall", 1'b1, 8'hAA, 1'b0);
            bus.in1 = bus.in1 + 8'h01;
        end
        bus.in1 = 8'h33;
        bus.out_ready = 1'b1;
        chk_rdy("bp_rel", 1'b0, 1'b1);
        tick(); chk_out("bp_rel", 1'b1, 8'h44, 1'b1);

        // Drain: nothing valid, output empties and holds data/sel
        bus.in1_valid = 1'b0; bus.in2_valid = 1'b0;
        chk_rdy("drain", 1'b0, 1'b0);
        tick(); chk_out("drain0", 1'b0, 8'h44, 1'b1);
        tick(); chk_out("drain1", 1'b0, 8'h44, 1'b1);

        // Idle cycles did not move the pointer: in1 wins next
        bus.in1_valid = 1'b1; bus.in2_valid = 1'b1;
        chk_rdy("ptr", 1'b1, 1'b0);
        tick(); chk_out("ptr", 1'b1, 8'h33, 1'b0);

        // Reset mid-operation drops the held beat and resets the pointer
        rst = 1'b1;
        chk_rdy("mrst", 1'b0, 1'b0);
        tick(); chk_out("mrst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        chk_rdy("mrst_rel", 1'b1, 1'b0);
        tick(); chk_out("mrst_rel", 1'b1, 8'h33, 1'b0);

`ifdef ARB_MUX2_PKT_LOCK_EN
        // Packet lock: 3-beat packet on in1 with a 2-cycle gap, in2 always valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in2 = 8'h22; bus.in2_valid = 1'b1; bus.in2_last = 1'b1;
        bus.in1 = 8'hB1; bus.in1_valid = 1'b1; bus.in1_last = 1'b0;
        chk_rdy("lk_b1", 1'b1, 1'b0);
        tick(); chk_out("lk_b1", 1'b1, 8'hB1, 1'b0);
        chk("lk_b1_last", bus.out_last, 1'b0);
        bus.in1_valid = 1'b0;
        chk_rdy("lk_gap0", 1'b0, 1'b0);
        tick(); chk("lk_gap0_v", bus.out_valid, 1'b0);
        chk_rdy("lk_gap1", 1'b0, 1'b0);
        tick(); chk("lk_gap1_v", bus.out_valid, 1'b0);
        bus.in1 = 8'hB2; bus.in1_valid = 1'b1;
        chk_rdy("lk_b2", 1'b1, 1'b0);
        tick(); chk_out("lk_b2", 1'b1, 8'hB2, 1'b0);
        bus.in1 = 8'hB3; bus.in1_last = 1'b1;
        chk_rdy("lk_b3", 1'b1, 1'b0);
        tick(); chk_out("lk_b3", 1'b1, 8'hB3, 1'b0);
        chk("lk_b3_last", bus.out_last, 1'b1);
        chk_rdy("lk_rel", 1'b0, 1'b1);
        tick(); chk_out("lk_rel", 1'b1, 8'h22, 1'b1);
        chk("lk_rel_last", bus.out_last, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arb_mux2.md
Name: arb_mux2

Overview:
- Two-input stream arbiter with a registered 2:1 data path and valid/ready handshakes on both sides.
- Round-robin arbitration picks one input per cycle; the winning beat is captured into a one-entry output register.
- Sits directly upstream of consumers that need a single merged stream, e.g. two requesters sharing one port.
- Drives the select internally and reports which source produced each output beat.

Parameters:
- WIDTH, 8, data width of in1, in2 and out.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in1  input  WIDTH  data from source 0.
- in1_valid  input  1  source 0 beat valid.
- in1_ready  output  1  source 0 beat accepted this cycle (when in1_valid is also high).
- in2  input  WIDTH  data from source 1.
- in2_valid  input  1  source 1 beat valid.
- in2_ready  output  1  source 1 beat accepted this cycle (when in2_valid is also high).
- out  output  WIDTH  registered merged data.
- out_valid  output  1  out holds a beat.
- out_ready  input  1  downstream accepts the out beat.
- out_sel  output  1  source of the current out beat: 0 = in1, 1 = in2.
- in1_last, in2_last  input  1  end-of-packet flags; present only with ARB_MUX2_PKT_LOCK_EN.
- out_last  output  1  registered end-of-packet flag; present only with ARB_MUX2_PKT_LOCK_EN.

Behaviour:
- Reset values:
  - out_valid = 0, out = 0, out_sel = 0.
  - Round-robin pointer favours in1 first (last_grant = 1).
  - Lock cleared; out_last = 0.
- Reset mid-operation discards any held beat. No handshake completes in a cycle where rst = 1; in1_ready = in2_ready = 0 while rst = 1.
- load = !out_valid || out_ready.
- Arbitration (combinational), choice c:
  - Only in1_valid high: c = 0.
  - Only in2_valid high: c = 1.
  - Both high: c = !last_grant.
  - Neither high: no choice.
- Ready generation:
  - in1_ready = load && in1_valid && c==0.
  - in2_ready = load && in2_valid && c==1.
  - Ready may depend on the other input's valid.
  - Never assert both readies in the same cycle.
- Transfer edge (load and at least one valid):
  - out <= chosen data; out_sel <= c; out_valid <= 1; last_grant <= c.
- Load with no valid input: out_valid <= 0; out and out_sel hold their previous values.
- !load (out_valid = 1, out_ready = 0):
  - out, out_sel and out_valid hold; both readies are 0.
  - Input data may change without effect.
- Latency: input beat to out_valid is 1 cycle.
- Throughput: 1 beat per cycle when out_ready is held high; no bubble on back-to-back transfers.
- Fairness:
  - Both inputs continuously valid: grants alternate 0,1,0,1...
  - A single active input is granted every cycle; pointer still updates.
- Pointer updates only on an accepted beat, never on idle or stalled cycles.

Optional Feature:
- Macro: ARB_MUX2_PKT_LOCK_EN.
- Enabled (packet lock):
  - Adds the *_last ports.
  - Once a beat with last = 0 is accepted from source X, arbitration is locked to X: c = X regardless of the other input's valid, and the other ready stays 0.
  - The lock persists through idle cycles of X.
  - The beat with last = 1 releases the lock.
  - last_grant updates only on last = 1 beats.
  - out_last <= chosen last on transfer.
  - Reset clears the lock.
- Disabled: no *_last ports; every beat is arbitrated independently as above.

Test Plan:
- Reset: rst=1 for 2 cycles with both inputs valid -> out_valid=0, out=0, out_sel=0, in1_ready=in2_ready=0; first cycle after release grants in1.
- Contention: in1=0x11, in2=0x22 both valid for 4 cycles, out_ready=1 -> out sequence 0x11,0x22,0x11,0x22 with out_sel 0,1,0,1, each 1 cycle after acceptance.
- Single source: only in2_valid, data 0x01..0x04, out_ready=1 -> out 0x01..0x04 on consecutive cycles, out_sel=1, no bubbles.
- Backpressure: out_valid=1 holding 0xAA, out_ready=0 for 3 cycles with both inputs valid -> out stays 0xAA, both readies 0; out_ready=1 -> next granted beat appears the following cycle.
- Drain: one beat accepted, then no valid inputs and out_ready=1 -> out_valid falls to 0 one cycle after the out handshake; out holds last value.
- Lock (ARB_MUX2_PKT_LOCK_EN): in1 sends 3-beat packet (last on beat 3) while in2 is continuously valid, including a 2-cycle in1_valid gap -> in2_ready=0 until in1's last beat accepted, then in2 granted next.
